cic_decimator: RTL



---
 rtl/cic_decimator.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cic_decimator.sv
// -----------------------------------------------------------------------------
// cic_decimator
//
// CIC decimation filter. It turns a 1-bit sigma-delta stream into signed PCM
// words. The input bit maps to +1 or -1. ORDER integrators run at the input
// rate and advance only on qualified samples. ORDER combs run once per RATIO
// accepted samples. The comb result is arithmetically shifted right by SHIFT
// and then saturated to OUT_W bits.
//
// Outputs are suppressed while the filter fills. The first ORDER decimated
// results after reset still update dout, but they raise no strobe.
//
// Ports
//   clk        : system clock
//   rst        : synchronous reset, active-high; clears every register
//   stream_in  : sigma-delta bit, 1 -> +1, 0 -> -1
//   in_valid   : stream_in is consumed only on cycles where this is 1
//   dout       : signed decimated sample, held between updates
//   dout_valid : one-cycle strobe marking a new, settled dout
// -----------------------------------------------------------------------------
module cic_decimator #(
   parameter int ORDER = 3,
   parameter int RATIO = 16,
   parameter int OUT_W = 16,
   parameter int SHIFT = 0,
   parameter int ACC_W = ORDER * $clog2(RATIO) + 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    stream_in,
   input  logic                    in_valid,
   output logic signed [OUT_W-1:0] dout,
   output logic                    dout_valid
);

   localparam int CNT_W  = $clog2(RATIO);
   localparam int WU_W   = $clog2(ORDER + 1);
   // Working width for saturation. It is wide enough that the range check
   // below never needs a negative-width slice, whatever ACC_W vs OUT_W is.
   localparam int WIDE_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);
   localparam logic [WU_W-1:0]  WU_FULL  = WU_W'(ORDER);

   localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

   // Clip a signed ACC_W value into OUT_W bits. The value fits when every
   // bit from OUT_W-1 upward equals the sign. Otherwise it clamps to the
   // rail on the side given by the sign.
   function automatic logic signed [OUT_W-1:0] saturate(
      input logic signed [ACC_W-1:0] v
   );
      logic signed [WIDE_W-1:0] w;
      logic [WIDE_W-OUT_W:0]    hi;
      w  = {{(WIDE_W-ACC_W){v[ACC_W-1]}}, v};
      hi = w[WIDE_W-1:OUT_W-1];
      if ((&hi) || !(|hi)) begin
         saturate = w[OUT_W-1:0];
      end else if (w[WIDE_W-1]) begin
         saturate = OUT_MIN;
      end else begin
         saturate = OUT_MAX;
      end
   endfunction

   logic signed [ACC_W-1:0] integ_r   [ORDER];
   logic signed [ACC_W-1:0] comb_d_r  [ORDER];
   logic signed [ACC_W-1:0] comb_in_s [ORDER];
   logic signed [ACC_W-1:0] comb_out_s;
   logic signed [ACC_W-1:0] shifted_s;
   logic signed [ACC_W-1:0] x_s;
   logic [CNT_W-1:0]        cnt_r;
   logic [WU_W-1:0]         wu_r;
   logic                    tick_s;

   // Map the modulator bit onto +1 / -1 at accumulator width.
   always_comb begin
      if (stream_in) begin
         x_s = {{(ACC_W-1){1'b0}}, 1'b1};
      end else begin
         x_s = {ACC_W{1'b1}};
      end
   end

   // A decimation tick occurs on the last accepted sample of a frame.
   assign tick_s = in_valid && (cnt_r == CNT_LAST);

   // Integrator cascade. Each stage adds the pre-update value of the stage
   // before it, which gives one register delay per stage. Wrap is intended.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < ORDER; k++) begin
            integ_r[k] <= '0;
         end
      end else if (in_valid) begin
         integ_r[0] <= integ_r[0] + x_s;
         for (int k = 1; k < ORDER; k++) begin
            integ_r[k] <= integ_r[k] + integ_r[k-1];
         end
      end
   end

   // Phase counter over accepted samples. It holds on unqualified cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (in_valid) begin
         if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end
   end

   // Comb chain: a combinational ripple of differences fed by the last
   // integrator. comb_in_s[k] is the input of stage k, and it becomes that
   // stage's delay value on a tick.
   always_comb begin
      logic signed [ACC_W-1:0] c;
      c = integ_r[ORDER-1];
      for (int k = 0; k < ORDER; k++) begin
         comb_in_s[k] = c;
         c            = c - comb_d_r[k];
      end
      comb_out_s = c;
   end

   assign shifted_s = comb_out_s >>> SHIFT;

   // Comb delay registers advance only on ticks.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < ORDER; k++) begin
            comb_d_r[k] <= '0;
         end
      end else if (tick_s) begin
         for (int k = 0; k < ORDER; k++) begin
            comb_d_r[k] <= comb_in_s[k];
         end
      end
   end

   // Warm-up counter. It counts ticks until the comb delays hold real history.
   always_ff @(posedge clk) begin
      if (rst) begin
         wu_r <= '0;
      end else if (tick_s && (wu_r != WU_FULL)) begin
         wu_r <= wu_r + WU_W'(1);
      end
   end

   // Output register. dout updates on every tick. The strobe is raised only
   // once the warm-up count had already completed before this tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else if (tick_s) begin
         dout       <= saturate(shifted_s);
         dout_valid <= (wu_r == WU_FULL);
      end else begin
         dout_valid <= 1'b0;
      end
   end

endmodule
